// File: rtl/hitmark_pkg.sv
// Shared types and slot register map for the hitmark sprite controllers.
package hitmark_pkg;

   typedef enum logic [3:0] {
      StInit,
      StIdle,
      StArmed,
      StWrX,
      StWrY,
      StWrC,
      StWrShow,
      StHold,
      StWrHide
   } state_e;

   localparam logic [13:0] REG_BYPASS = 14'h2000;
   localparam logic [13:0] REG_X0     = 14'h2001;
   localparam logic [13:0] REG_Y0     = 14'h2002;
   localparam logic [13:0] REG_CTRL   = 14'h2003;

   // Clamps at 0 so hits near the screen edge never wrap to the far side.
   function automatic logic [10:0] sat_sub(input logic [10:0] a, input logic [10:0] b);
      return (a > b) ? (a - b) : 11'd0;
   endfunction

endpackage

// File: rtl/slot_write_gen.sv
// Registered single-cycle slot write generator; addr/data are forced to 0 when idle.
module slot_write_gen (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        wr_en_i,
   input  logic [13:0] wr_addr_i,
   input  logic [31:0] wr_data_i,
   output logic        cs_o,
   output logic        write_o,
   output logic [13:0] addr_o,
   output logic [31:0] data_o
);

   logic        en_q;
   logic [13:0] addr_q;
   logic [31:0] data_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         en_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         en_q   <= wr_en_i;
         addr_q <= wr_en_i ? wr_addr_i : 14'd0;
         data_q <= wr_en_i ? wr_data_i : 32'd0;
      end
   end

   assign cs_o    = en_q;
   assign write_o = en_q;
   assign addr_o  = addr_q;
   assign data_o  = data_q;

endmodule

// File: rtl/hitmark_anim_ctrl.sv
// Hit-triggered hitmark sprite sequencer: places the sprite, steps its animation on
// frame ticks and hides it when done, all through the sprite core's register slot.
module hitmark_anim_ctrl
   import hitmark_pkg::*;
#(
   parameter int unsigned NUM_STEPS       = 4,
   parameter int unsigned FRAMES_PER_STEP = 6,
   parameter logic [4:0]  CTRL_BASE       = 5'b00100,
   parameter int unsigned X_OFS           = 16,
   parameter int unsigned Y_OFS           = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        frame_tick,
   input  logic        hit_valid,
   input  logic [10:0] hit_x,
   input  logic [10:0] hit_y,
   output logic        hit_ready,
   output logic        busy,
   output logic        cs,
   output logic        write,
   output logic [13:0] addr,
   output logic [31:0] wr_data
);

   localparam logic [3:0]  STEP_LAST = 4'(NUM_STEPS - 1);
   localparam logic [5:0]  FC_LAST   = 6'(FRAMES_PER_STEP - 1);
   localparam logic [10:0] XOFS      = 11'(X_OFS);
   localparam logic [10:0] YOFS      = 11'(Y_OFS);

   state_e      state_q, state_d;
   logic [10:0] x0_q, x0_d;
   logic [10:0] y0_q, y0_d;
   logic [3:0]  step_q, step_d;
   logic [5:0]  fc_q, fc_d;
   logic        visible_q, visible_d;

   logic        wr_en;
   logic [13:0] wr_addr;
   logic [31:0] wr_val;
   logic [4:0]  ctrl_val;

   assign ctrl_val = 5'(CTRL_BASE + 5'(step_q));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StInit;
         x0_q      <= '0;
         y0_q      <= '0;
         step_q    <= '0;
         fc_q      <= '0;
         visible_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         x0_q      <= x0_d;
         y0_q      <= y0_d;
         step_q    <= step_d;
         fc_q      <= fc_d;
         visible_q <= visible_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      x0_d      = x0_q;
      y0_d      = y0_q;
      step_d    = step_q;
      fc_d      = fc_q;
      visible_d = visible_q;
      wr_en     = 1'b0;
      wr_addr   = 14'd0;
      wr_val    = 32'd0;
      hit_ready = 1'b0;

      unique case (state_q)
         StInit: begin
            wr_en   = 1'b1;
            wr_addr = REG_BYPASS;
            wr_val  = 32'd1;
            state_d = StIdle;
         end
         StIdle: begin
            hit_ready = 1'b1;
            if (hit_valid) begin
               x0_d    = sat_sub(hit_x, XOFS);
               y0_d    = sat_sub(hit_y, YOFS);
               step_d  = 4'd0;
               fc_d    = 6'd0;
               state_d = StArmed;
            end
         end
         StArmed: begin
            if (frame_tick) state_d = StWrX;
         end
         StWrX: begin
            wr_en   = 1'b1;
            wr_addr = REG_X0;
            wr_val  = {21'd0, x0_q};
            state_d = StWrY;
         end
         StWrY: begin
            wr_en   = 1'b1;
            wr_addr = REG_Y0;
            wr_val  = {21'd0, y0_q};
            state_d = StWrC;
         end
         StWrC: begin
            wr_en   = 1'b1;
            wr_addr = REG_CTRL;
            wr_val  = {27'd0, ctrl_val};
            // A retrigger keeps the sprite shown, so the un-bypass write is skipped.
            state_d = (step_q == 4'd0 && !visible_q) ? StWrShow : StHold;
         end
         StWrShow: begin
            wr_en     = 1'b1;
            wr_addr   = REG_BYPASS;
            wr_val    = 32'd0;
            visible_d = 1'b1;
            state_d   = StHold;
         end
         StHold: begin
            hit_ready = 1'b1;
            if (hit_valid) begin
               x0_d    = sat_sub(hit_x, XOFS);
               y0_d    = sat_sub(hit_y, YOFS);
               step_d  = 4'd0;
               fc_d    = 6'd0;
               state_d = StArmed;
            end else if (frame_tick) begin
               if (fc_q == FC_LAST) begin
                  fc_d = 6'd0;
                  if (step_q == STEP_LAST) begin
                     state_d = StWrHide;
                  end else begin
                     step_d  = step_q + 4'd1;
                     state_d = StWrC;
                  end
               end else begin
                  fc_d = fc_q + 6'd1;
               end
            end
         end
         StWrHide: begin
            wr_en     = 1'b1;
            wr_addr   = REG_BYPASS;
            wr_val    = 32'd1;
            visible_d = 1'b0;
            state_d   = StIdle;
         end
         default: state_d = StInit;
      endcase
   end

   assign busy = visible_q || (state_q == StWrShow);

   slot_write_gen u_slot_write_gen (
      .clk_i     (clk),
      .rst_ni    (reset_n),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_val),
      .cs_o      (cs),
      .write_o   (write),
      .addr_o    (addr),
      .data_o    (wr_data)
   );

endmodule

// File: tb/tb_hitmark_anim_ctrl.sv
// Scoreboard bench for hitmark_anim_ctrl: stimulus queues expected slot writes,
// a negedge monitor pops and compares every write the DUT issues.
module tb_hitmark_anim_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        frame_tick;
   logic        hit_valid;
   logic [10:0] hit_x;
   logic [10:0] hit_y;
   logic        hit_ready;
   logic        busy;
   logic        cs;
   logic        write;
   logic [13:0] addr;
   logic [31:0] wr_data;

   int n_total = 0;
   int n_pass  = 0;
   logic [45:0] exp_q[$];

   always #5 clk = ~clk;

   hitmark_anim_ctrl dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .frame_tick (frame_tick),
      .hit_valid  (hit_valid),
      .hit_x      (hit_x),
      .hit_y      (hit_y),
      .hit_ready  (hit_ready),
      .busy       (busy),
      .cs         (cs),
      .write      (write),
      .addr       (addr),
      .wr_data    (wr_data)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic push(input logic [13:0] a, input logic [31:0] d);
      exp_q.push_back({a, d});
   endtask

   // Monitor: every slot write must match the head of the expectation queue.
   always @(negedge clk) begin
      logic [45:0] e;
      if (cs || write) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_write: addr %h data %h, no write expected", addr, wr_data);
         end else begin
            e = exp_q.pop_front();
            chk("slot_write", {16'd0, cs, write, addr, wr_data}, {16'd0, 2'b11, e});
         end
      end else if (addr != 14'd0 || wr_data != 32'd0) begin
         n_total++;
         $display("FAIL idle_bus: addr %h data %h, required 0/0", addr, wr_data);
      end
   end

   task automatic do_tick();
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk(name, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   task automatic hit(input logic [10:0] x, input logic [10:0] y, input logic with_tick);
      @(negedge clk);
      chk("hit_ready_before_hit", {63'd0, hit_ready}, 64'd1);
      hit_valid  = 1'b1;
      hit_x      = x;
      hit_y      = y;
      frame_tick = with_tick;
      @(negedge clk);
      hit_valid  = 1'b0;
      frame_tick = 1'b0;
   endtask

   // Remaining ctrl steps after start_step, then the hide write.
   task automatic run_tail(input int start_step);
      for (int k = start_step + 1; k < 4; k++) begin
         repeat (5) do_tick();
         push(14'h2003, 32'(4 + k));
         do_tick();
         drain("ctrl_step");
      end
      repeat (5) do_tick();
      chk("busy_before_hide", {63'd0, busy}, 64'd1);
      push(14'h2000, 32'd1);
      do_tick();
      drain("hide_write");
      chk("busy_after_hide", {63'd0, busy}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n    = 1'b0;
      frame_tick = 1'b0;
      hit_valid  = 1'b0;
      hit_x      = '0;
      hit_y      = '0;
      #1;
      chk("reset_outputs", {15'd0, cs, write, addr, wr_data, busy, hit_ready}, 64'd0);

      // 1: reset release gives exactly one hide write
      push(14'h2000, 32'd1);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      drain("init_hide");
      repeat (5) @(negedge clk);
      chk("idle_busy", {63'd0, busy}, 64'd0);
      chk("idle_ready", {63'd0, hit_ready}, 64'd1);

      // 2: full animation at (200,120)
      hit(11'd200, 11'd120, 1'b0);
      chk("armed_ready", {63'd0, hit_ready}, 64'd0);
      push(14'h2001, 32'd184);
      push(14'h2002, 32'd104);
      push(14'h2003, 32'd4);
      push(14'h2000, 32'd0);
      do_tick();
      drain("burst_200_120");
      chk("busy_shown", {63'd0, busy}, 64'd1);
      run_tail(0);

      // 3: saturation near origin
      hit(11'd5, 11'd3, 1'b0);
      push(14'h2001, 32'd0);
      push(14'h2002, 32'd0);
      push(14'h2003, 32'd4);
      push(14'h2000, 32'd0);
      do_tick();
      drain("burst_saturated");
      run_tail(0);

      // 5: tick during WR_Y is ignored
      hit(11'd200, 11'd120, 1'b0);
      push(14'h2001, 32'd184);
      push(14'h2002, 32'd104);
      push(14'h2003, 32'd4);
      push(14'h2000, 32'd0);
      @(negedge clk); frame_tick = 1'b1;
      @(negedge clk); frame_tick = 1'b0;
      @(negedge clk); frame_tick = 1'b1;
      @(negedge clk); frame_tick = 1'b0;
      repeat (8) @(negedge clk);
      drain("burst_tick_in_wry");
      repeat (5) do_tick();
      push(14'h2003, 32'd5);
      do_tick();
      drain("ctrl5_after_ignored_tick");
      repeat (5) do_tick();
      push(14'h2003, 32'd6);
      do_tick();
      drain("ctrl6");

      // 4: retrigger at step 2 with a coincident tick
      repeat (3) do_tick();
      hit(11'd400, 11'd300, 1'b1);
      chk("busy_retrigger", {63'd0, busy}, 64'd1);
      push(14'h2001, 32'd384);
      push(14'h2002, 32'd284);
      push(14'h2003, 32'd4);
      do_tick();
      drain("retrigger_burst");
      chk("busy_after_retrigger", {63'd0, busy}, 64'd1);
      run_tail(0);

      // 6: reset during WR_Y
      hit(11'd200, 11'd120, 1'b0);
      push(14'h2001, 32'd184);
      @(negedge clk); frame_tick = 1'b1;
      @(negedge clk); frame_tick = 1'b0;
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("midreset_outputs", {15'd0, cs, write, addr, wr_data, busy, hit_ready}, 64'd0);
      chk("x0_before_reset", 64'(exp_q.size()), 64'd0);
      repeat (2) @(negedge clk);
      push(14'h2000, 32'd1);
      reset_n = 1'b1;
      drain("init_hide_after_reset");
      repeat (3) @(negedge clk);
      hit(11'd5, 11'd3, 1'b0);
      push(14'h2001, 32'd0);
      push(14'h2002, 32'd0);
      push(14'h2003, 32'd4);
      push(14'h2000, 32'd0);
      do_tick();
      drain("burst_after_reset");
      chk("busy_after_reset_hit", {63'd0, busy}, 64'd1);

      repeat (4) @(negedge clk);
      chk("queue_empty_end", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
